req_round_robin_scheduler: RTL and testbench

REQ_ROUND_ROBIN_SCHEDULER -- requirements
Module: req_round_robin_scheduler

---
 rtl/req_round_robin_scheduler_pkg.sv | 14 +
 rtl/req_round_robin_scheduler_if.sv | 25 ++
 rtl/req_round_robin_scheduler_rr_mask_gen.sv | 21 ++
 rtl/req_round_robin_scheduler.sv | 107 ++++++++++
 tb/tb_req_round_robin_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/req_round_robin_scheduler_pkg.sv
// Shared types and constants for the request round-robin scheduler.
// Holds the FSM state enum and the default request-line count.
package req_round_robin_scheduler_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_OUT_WIDTH = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        OFFER = 2'd2
    } state_t;

endpackage

// File: rtl/req_round_robin_scheduler_if.sv
// Grant handshake bundle between the scheduler and its consumer.
// Ports: grant_idx/grant_valid (master out), grant_ready (slave out).
interface req_round_robin_scheduler_if
    import req_round_robin_scheduler_pkg::*;
#(
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);

    logic [OUT_WIDTH-1:0] grant_idx;
    logic                 grant_valid;
    logic                 grant_ready;

    modport master (
        output grant_idx,
        output grant_valid,
        input  grant_ready
    );

    modport slave (
        input  grant_idx,
        input  grant_valid,
        output grant_ready
    );

endinterface

// File: rtl/req_round_robin_scheduler_rr_mask_gen.sv
// Thermometer mask from the last granted index (bits >= last_idx blocked).
// Ports: en (mask active), last_idx (last grant), mask (1 = blocked).
module rr_mask_gen
    import req_round_robin_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = $clog2(WIDTH)
) (
    input  logic                 en,
    input  logic [OUT_WIDTH-1:0] last_idx,
    output logic [WIDTH-1:0]     mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = en && (i >= int'(last_idx));
        end
    end

endmodule

// File: rtl/req_round_robin_scheduler.sv
// Round-robin scheduler: latches request pulses, arbitrates via an external
// priority encoder and offers one grant at a time on a valid/ready bundle.
// Ports: clk, rst (sync, active high), req_in, enc_data/enc_mask (to
// encoder), enc_idx/enc_valid (from encoder), gnt (grant master), pending.
// Build option: define RR_MASK_EN for round-robin masking; otherwise the
// highest pending index always wins.
module req_round_robin_scheduler
    import req_round_robin_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req_in,
    output logic [WIDTH-1:0]     enc_data,
    output logic [WIDTH-1:0]     enc_mask,
    input  logic [OUT_WIDTH-1:0] enc_idx,
    input  logic                 enc_valid,
    req_round_robin_scheduler_if.master gnt,
    output logic [WIDTH-1:0]     pending
);

    state_t               state;
    logic [OUT_WIDTH-1:0] grant_idx;
    logic                 grant_valid;
    logic                 hs;
    logic [WIDTH-1:0]     clr;
    logic [WIDTH-1:0]     pend_nxt;

    assign gnt.grant_idx   = grant_idx;
    assign gnt.grant_valid = grant_valid;

    assign hs       = grant_valid && gnt.grant_ready;
    assign clr      = hs ? ({{(WIDTH-1){1'b0}}, 1'b1} << grant_idx) : '0;
    // A request on the bit being cleared this cycle keeps it pending.
    assign pend_nxt = (pending & ~clr) | req_in;
    assign enc_data = pending;

`ifdef RR_MASK_EN
    logic [OUT_WIDTH-1:0] last_idx;
    logic                 rr_on;

    rr_mask_gen #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_mask (
        .en       (rr_on),
        .last_idx (last_idx),
        .mask     (enc_mask)
    );
`else
    assign enc_mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
`ifdef RR_MASK_EN
            last_idx    <= '0;
            rr_on       <= 1'b0;
`endif
        end else begin
            pending <= pend_nxt;
            unique case (state)
                IDLE: begin
                    // Test the value being loaded so a fresh request
                    // reaches ARB on the very next cycle.
                    if (|pend_nxt) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (enc_valid) begin
                        grant_idx   <= enc_idx;
                        grant_valid <= 1'b1;
                        state       <= OFFER;
`ifdef RR_MASK_EN
                    end else if (|enc_mask) begin
                        // Nothing below last_idx: wrap to the top.
                        rr_on <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                OFFER: begin
                    if (gnt.grant_ready) begin
                        grant_valid <= 1'b0;
`ifdef RR_MASK_EN
                        last_idx    <= grant_idx;
                        rr_on       <= 1'b1;
`endif
                        state <= (|pend_nxt) ? ARB : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_round_robin_scheduler.sv
// Self-checking bench for req_round_robin_scheduler: directed vector table
// followed by randomized traffic against a transaction-level model.
module tb_req_round_robin_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req_in;
    logic [15:0] enc_data;
    logic [15:0] enc_mask;
    logic [3:0]  enc_idx;
    logic        enc_valid;
    logic [15:0] pending;

    req_round_robin_scheduler_if #(.OUT_WIDTH(4)) gnt_if ();

    req_round_robin_scheduler #(
        .WIDTH     (16),
        .OUT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .enc_data  (enc_data),
        .enc_mask  (enc_mask),
        .enc_idx   (enc_idx),
        .enc_valid (enc_valid),
        .gnt       (gnt_if),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External priority encoder: highest-index unmasked set bit.
    always_comb begin
        enc_valid = 1'b0;
        enc_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (enc_data[i] && !enc_mask[i]) begin
                enc_valid = 1'b1;
                enc_idx   = 4'(i);
            end
        end
    end

    typedef struct {
        logic        r;
        logic [15:0] q;
        logic        y;
        logic        gv;
        logic [3:0]  gi;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(input logic r, input logic [15:0] q, input logic y,
                       input logic gv, input logic [3:0] gi,
                       input logic [15:0] p);
        vec_t v;
        v.r = r; v.q = q; v.y = y; v.gv = gv; v.gi = gi; v.p = p;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic int hi_bit(input logic [15:0] v, input int lim);
        int r;
        r = -1;
        for (int i = 0; i < 16; i++) begin
            if (i < lim && v[i]) r = i;
        end
        return r;
    endfunction

    logic [15:0] m_pend;
    logic [3:0]  m_last;
    logic        m_armed;
    logic [3:0]  m_gi;

    function automatic int pick(input logic [15:0] p);
        int e;
`ifdef RR_MASK_EN
        if (m_armed) begin
            e = hi_bit(p, int'(m_last));
            if (e < 0) e = hi_bit(p, 16);
        end else begin
            e = hi_bit(p, 16);
        end
`else
        e = hi_bit(p, 16);
`endif
        return e;
    endfunction

    initial begin
        logic        gv_b;
        logic        gv_prev;
        logic [3:0]  gi_b;
        logic        rdy;
        logic [15:0] rq;
        logic [15:0] clr;
        int          wait_c;
        int          e;

        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        req_in  = '0;
        gnt_if.grant_ready = 1'b0;

        // Single request, 2-cycle latency, request ignored under reset.
        add(1, 16'h0001, 0, 0, 0, 16'h0001 & 16'h0000);
        add(0, 16'h0001, 0, 0, 0, 16'h0001);
        add(0, 16'h0000, 0, 1, 0, 16'h0001);
        add(0, 16'h0000, 1, 0, 0, 16'h0000);
        add(0, 16'h0000, 0, 0, 0, 16'h0000);
        add(1, 16'h0000, 0, 0, 0, 16'h0000);
        // Held offer, then re-request on the granted bit at handshake.
        add(0, 16'h0010, 0, 0, 0, 16'h0010);
        add(0, 16'h0000, 0, 1, 4, 16'h0010);
        for (int k = 0; k < 5; k++) add(0, 16'h0000, 0, 1, 4, 16'h0010);
        add(0, 16'h0010, 1, 0, 4, 16'h0010);
`ifdef RR_MASK_EN
        add(0, 16'h0000, 0, 0, 4, 16'h0010);
`endif
        add(0, 16'h0000, 0, 1, 4, 16'h0010);
        add(0, 16'h0000, 1, 0, 4, 16'h0000);
        add(0, 16'h0000, 0, 0, 4, 16'h0000);
        add(1, 16'h0000, 0, 0, 0, 16'h0000);
        // Reset during an offer discards the grant.
        add(0, 16'h0100, 0, 0, 0, 16'h0100);
        add(0, 16'h0000, 0, 1, 8, 16'h0100);
        add(1, 16'h0002, 0, 0, 0, 16'h0000);
        add(0, 16'h0000, 1, 0, 0, 16'h0000);
        add(0, 16'h0000, 0, 0, 0, 16'h0000);
`ifdef RR_MASK_EN
        // Descending round robin over 15, 10, 5, 0.
        add(0, 16'h8421, 1, 0, 0,  16'h8421);
        add(0, 16'h0000, 1, 1, 15, 16'h8421);
        add(0, 16'h0000, 1, 0, 15, 16'h0421);
        add(0, 16'h0000, 1, 1, 10, 16'h0421);
        add(0, 16'h0000, 1, 0, 10, 16'h0021);
        add(0, 16'h0000, 1, 1, 5,  16'h0021);
        add(0, 16'h0000, 1, 0, 5,  16'h0001);
        add(0, 16'h0000, 1, 1, 0,  16'h0001);
        add(0, 16'h0000, 1, 0, 0,  16'h0000);
        add(0, 16'h0000, 1, 0, 0,  16'h0000);
        // Wrap from 0 back to 15.
        add(0, 16'h8001, 0, 0, 0,  16'h8001);
        add(0, 16'h0000, 0, 0, 0,  16'h8001);
        add(0, 16'h0000, 0, 1, 15, 16'h8001);
        add(0, 16'h8000, 1, 0, 15, 16'h8001);
        add(0, 16'h0000, 0, 1, 0,  16'h8001);
        add(0, 16'h0000, 1, 0, 0,  16'h8000);
        add(0, 16'h0000, 0, 0, 0,  16'h8000);
        add(0, 16'h0000, 0, 1, 15, 16'h8000);
        add(0, 16'h0000, 1, 0, 15, 16'h0000);
`else
        // Fixed priority: bit 12 re-requested keeps winning over bit 3.
        add(0, 16'h1008, 0, 0, 0,  16'h1008);
        add(0, 16'h0000, 0, 1, 12, 16'h1008);
        add(0, 16'h1000, 1, 0, 12, 16'h1008);
        add(0, 16'h0000, 0, 1, 12, 16'h1008);
        add(0, 16'h1000, 1, 0, 12, 16'h1008);
        add(0, 16'h0000, 0, 1, 12, 16'h1008);
        add(0, 16'h0000, 1, 0, 12, 16'h0008);
        add(0, 16'h0000, 0, 1, 3,  16'h0008);
        add(0, 16'h0000, 1, 0, 3,  16'h0000);
        add(0, 16'h0000, 0, 0, 3,  16'h0000);
`endif
        add(1, 16'h0000, 0, 0, 0, 16'h0000);
        add(0, 16'h0000, 0, 0, 0, 16'h0000);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst    = tbl[i].r;
            req_in = tbl[i].q;
            gnt_if.grant_ready = tbl[i].y;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.grant_valid", i),
                32'(gnt_if.grant_valid), 32'(tbl[i].gv));
            chk($sformatf("vec%0d.grant_idx", i),
                32'(gnt_if.grant_idx), 32'(tbl[i].gi));
            chk($sformatf("vec%0d.pending", i),
                32'(pending), 32'(tbl[i].p));
        end

`ifndef RR_MASK_EN
        chk("enc_mask_tied", 32'(enc_mask), 32'h0);
`endif

        // Randomized traffic; requests arrive only while idle or offering
        // so the set seen at capture equals the model set.
        m_pend  = '0;
        m_last  = '0;
        m_armed = 1'b0;
        m_gi    = '0;
        gv_prev = 1'b0;
        wait_c  = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gv_b = gnt_if.grant_valid;
            gi_b = gnt_if.grant_idx;
            chk("rnd.pending", 32'(pending), 32'(m_pend));
            chk("rnd.enc_data", 32'(enc_data), 32'(m_pend));
            if (gv_b && !gv_prev) begin
                e = pick(m_pend);
                chk("rnd.grant_in_pending", 32'(e >= 0), 32'd1);
                chk("rnd.offer_latency", 32'(wait_c <= 2), 32'd1);
                m_gi = 4'(e);
                chk("rnd.grant_pick", 32'(gi_b), 32'(m_gi));
                wait_c = 0;
            end else if (gv_b) begin
                chk("rnd.grant_hold", 32'(gi_b), 32'(m_gi));
            end
            if (!gv_b && m_pend != 0) wait_c++;
            if (wait_c > 8) begin
                chk("rnd.stall_cycles", 32'(wait_c), 32'd2);
                wait_c = 0;
            end
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) rq = 16'hFFFF;
            else rq = 16'($urandom & $urandom & $urandom);
            if (!(gv_b || m_pend == 0)) rq = '0;
            rst    = 1'b0;
            req_in = rq;
            gnt_if.grant_ready = rdy;
            if (gv_b && rdy) begin
                clr     = 16'(16'h0001 << m_gi);
                m_last  = m_gi;
                m_armed = 1'b1;
            end else begin
                clr = '0;
            end
            m_pend  = (m_pend & ~clr) | rq;
            gv_prev = gv_b;
        end
        chk("rnd.final_stall", 32'(wait_c <= 2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
